// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: access sizes, FSM states
// and transaction owner.
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_beat_packer.sv
// Combinational beat helper: beat count and alignment check for an access size,
// MSB-first store byte selection and load-value extension.
module mem_beat_packer
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_beat,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_raw,
    input  logic        i_se,
    output logic [2:0]  o_nbeats,
    output logic        o_err,
    output logic [7:0]  o_wbyte,
    output logic [31:0] o_rdata_ext
);

    logic [1:0] w_last;
    logic [1:0] w_idx;

    always_comb begin
        w_last = 2'd0;
        o_err  = 1'b0;
        case (i_size)
            SZ_BYTE: w_last = 2'd0;
            SZ_HALF: begin
                w_last = 2'd1;
                o_err  = i_addr_lo[0];
            end
            SZ_WORD: begin
                w_last = 2'd3;
                o_err  = |i_addr_lo;
            end
            default: o_err = 1'b1;
        endcase
        o_nbeats = {1'b0, w_last} + 3'd1;
    end

    // Beat 0 carries the most significant byte of the N-byte value.
    assign w_idx   = w_last - i_beat;
    assign o_wbyte = i_wdata[{w_idx, 3'b000} +: 8];

    always_comb begin
        o_rdata_ext = i_raw;
        case (i_size)
            SZ_BYTE: o_rdata_ext = {{24{i_se & i_raw[7]}}, i_raw[7:0]};
            SZ_HALF: o_rdata_ext = {{16{i_se & i_raw[15]}}, i_raw[15:0]};
            default: o_rdata_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto a byte-wide single-port memory,
// sequencing each access as 1/2/4 beats and reporting done/stall to the pipeline.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter bit          DM_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic [1:0]        dm_size,
    input  logic              dm_se,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_done,
    output logic              dm_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              pipe_stall
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    arb_owner_e        r_owner;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_size;
    logic [1:0]        r_beat;
    logic              r_rw;
    logic              r_se;
    logic              r_err;
    logic [31:0]       r_wdata;
    logic [31:0]       r_shift;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_dm_rdata;

    logic              w_grant_dm;
    logic              w_grant_if;
    logic              w_grant;
    logic [1:0]        w_cand_size;
    logic [ADDR_W-1:0] w_cand_addr;
    logic [1:0]        w_pk_size;
    logic [2:0]        w_nbeats;
    logic              w_pk_err;
    logic [7:0]        w_wbyte;
    logic [31:0]       w_raw;
    logic [31:0]       w_rdata_ext;
    logic              w_last;

    assign w_grant_dm  = dm_req & (~if_req | DM_PRIORITY);
    assign w_grant_if  = if_req & ~w_grant_dm;
    assign w_grant     = w_grant_dm | w_grant_if;
    assign w_cand_size = w_grant_dm ? dm_size : SZ_WORD;
    assign w_cand_addr = w_grant_dm ? dm_addr : if_addr;

    // In IDLE the packer judges the candidate request; afterwards the latched one.
    assign w_pk_size = (r_state == IDLE) ? w_cand_size : r_size;
    assign w_raw     = {r_shift[23:0], mem_rdata};
    assign w_last    = ({1'b0, r_beat} == (w_nbeats - 3'd1));

    mem_beat_packer u_packer (
        .i_size      (w_pk_size),
        .i_addr_lo   (w_cand_addr[1:0]),
        .i_beat      (r_beat),
        .i_wdata     (r_wdata),
        .i_raw       (w_raw),
        .i_se        (r_se),
        .o_nbeats    (w_nbeats),
        .o_err       (w_pk_err),
        .o_wbyte     (w_wbyte),
        .o_rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_next = w_pk_err ? RESP : XFER;
                end
            end
            XFER: begin
                if (w_last) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        dm_err    = 1'b0;
        case (r_state)
            XFER: begin
                mem_addr  = r_base + ADDR_W'(r_beat);
                mem_we    = r_rw;
                mem_wdata = r_rw ? w_wbyte : 8'h00;
            end
            RESP: begin
                if (r_owner == OWN_DM) begin
                    dm_done = 1'b1;
                    dm_err  = r_err;
                end else begin
                    if_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= OWN_IF;
            r_base     <= '0;
            r_size     <= SZ_BYTE;
            r_beat     <= 2'd0;
            r_rw       <= 1'b0;
            r_se       <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= 32'h0;
            r_shift    <= 32'h0;
            r_if_rdata <= 32'h0;
            r_dm_rdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
                        r_base  <= w_cand_addr;
                        r_size  <= w_cand_size;
                        r_rw    <= w_grant_dm & dm_rw;
                        r_se    <= w_grant_dm & dm_se;
                        r_wdata <= dm_wdata;
                        r_err   <= w_pk_err;
                        r_beat  <= 2'd0;
                        r_shift <= 32'h0;
                        if (w_pk_err) begin
                            if (w_grant_dm) begin
                                r_dm_rdata <= 32'h0;
                            end else begin
                                r_if_rdata <= 32'h0;
                            end
                        end
                    end
                end
                XFER: begin
                    r_beat  <= r_beat + 2'd1;
                    r_shift <= w_raw;
                    // Final beat byte is still on mem_rdata, so commit the assembled value now.
                    if (w_last && !r_rw) begin
                        if (r_owner == OWN_DM) begin
                            r_dm_rdata <= w_rdata_ext;
                        end else begin
                            r_if_rdata <= w_rdata_ext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_rdata   = r_if_rdata;
    assign dm_rdata   = r_dm_rdata;
    assign pipe_stall = (if_req & ~if_done) | (dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a bench-side 512x8 combinational-read memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [8:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_rw;
    logic [1:0]  dm_size;
    logic        dm_se;
    logic [8:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_err;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        pipe_stall;

    logic [7:0]  mem [512];
    logic        tb_we;
    logic [8:0]  tb_waddr;
    logic [7:0]  tb_wdata;

    int n_checks;
    int n_errors;

    mem_port_arbiter #(
        .ADDR_W      (9),
        .DM_PRIORITY (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .dm_req     (dm_req),
        .dm_rw      (dm_rw),
        .dm_size    (dm_size),
        .dm_se      (dm_se),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .dm_err     (dm_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .pipe_stall (pipe_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_waddr = a;
        tb_wdata = d;
        tb_we    = 1'b1;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    // Cycle numbering: the grant edge is 0; done sampled at edge k+1 returns k+1, 0 on timeout.
    task automatic wait_dm(input int k0, output int cyc);
        cyc = 0;
        for (int k = k0; k < k0 + 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (dm_done) begin
                cyc = k + 1;
                break;
            end
        end
    endtask

    task automatic wait_if(input int k0, output int cyc);
        cyc = 0;
        for (int k = k0; k < k0 + 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_done) begin
                cyc = k + 1;
                break;
            end
        end
    endtask

    task automatic dm_start(input logic rw, input logic [1:0] sz, input logic se,
                            input logic [8:0] a, input logic [31:0] wd);
        dm_rw    = rw;
        dm_size  = sz;
        dm_se    = se;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
    endtask

    initial begin
        int  cyc;
        int  cyc_if;
        int  cyc_dm;
        bit  stall_ok;
        bit  we_seen;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_rw    = 1'b0;
        dm_size  = 2'b00;
        dm_se    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        tb_we    = 1'b0;
        tb_waddr = '0;
        tb_wdata = '0;

        poke(9'h000, 8'h24); poke(9'h001, 8'h05); poke(9'h002, 8'h00); poke(9'h003, 8'h10);
        poke(9'h013, 8'h80);
        poke(9'h040, 8'h11); poke(9'h041, 8'h22); poke(9'h042, 8'h33); poke(9'h043, 8'h44);
        poke(9'h102, 8'h5A);
        poke(9'h080, 8'h01); poke(9'h081, 8'h02); poke(9'h082, 8'h03); poke(9'h083, 8'h04);

        @(negedge clk);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {23'h0, mem_addr}, 32'h0);
        chk("rst_dones", {29'h0, if_done, dm_done, dm_err}, 32'h0);
        chk("rst_stall", {31'h0, pipe_stall}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Word fetch from 0x000.
        if_addr = 9'h000;
        if_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("fetch_addr%0d", k), {23'h0, mem_addr}, k);
            chk($sformatf("fetch_we%0d", k), {31'h0, mem_we}, 32'h0);
        end
        wait_if(4, cyc);
        chk("fetch_cycle", cyc, 5);
        chk("fetch_rdata", if_rdata, 32'h24050010);
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_done_pulse", {31'h0, if_done}, 32'h0);
        chk("idle_mem_addr", {23'h0, mem_addr}, 32'h0);

        // Signed byte load.
        dm_start(1'b0, 2'b00, 1'b1, 9'h013, 32'h0);
        wait_dm(0, cyc);
        chk("lb_cycle", cyc, 2);
        chk("lb_rdata", dm_rdata, 32'hFFFFFF80);
        chk("lb_err", {31'h0, dm_err}, 32'h0);
        dm_req = 1'b0;
        @(negedge clk);
        chk("lb_done_pulse", {31'h0, dm_done}, 32'h0);

        // Unsigned byte load.
        dm_start(1'b0, 2'b00, 1'b0, 9'h013, 32'h0);
        wait_dm(0, cyc);
        chk("lbu_cycle", cyc, 2);
        chk("lbu_rdata", dm_rdata, 32'h00000080);
        dm_req = 1'b0;
        @(negedge clk);
        chk("if_rdata_held", if_rdata, 32'h24050010);

        // Half store at 0x1FE.
        dm_start(1'b1, 2'b01, 1'b0, 9'h1FE, 32'h0000BEEF);
        @(posedge clk);
        @(negedge clk);
        chk("sh_we0", {31'h0, mem_we}, 32'h1);
        chk("sh_wdata0", {24'h0, mem_wdata}, 32'hBE);
        wait_dm(1, cyc);
        chk("sh_cycle", cyc, 3);
        chk("sh_byte0", {24'h0, mem[9'h1FE]}, 32'hBE);
        chk("sh_byte1", {24'h0, mem[9'h1FF]}, 32'hEF);
        chk("sh_rdata_kept", dm_rdata, 32'h00000080);
        dm_req = 1'b0;
        @(negedge clk);

        // Half load back, sign-extended.
        dm_start(1'b0, 2'b01, 1'b1, 9'h1FE, 32'h0);
        wait_dm(0, cyc);
        chk("lh_cycle", cyc, 3);
        chk("lh_rdata", dm_rdata, 32'hFFFFBEEF);
        dm_req = 1'b0;
        @(negedge clk);

        // Simultaneous IF word fetch and DM word load: DM wins.
        if_addr  = 9'h000;
        if_req   = 1'b1;
        dm_start(1'b0, 2'b10, 1'b0, 9'h040, 32'h0);
        cyc_if   = 0;
        cyc_dm   = 0;
        stall_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!if_done && !pipe_stall) stall_ok = 1'b0;
            if (dm_done) begin
                cyc_dm = k + 1;
                dm_req = 1'b0;
            end
            if (if_done) begin
                cyc_if = k + 1;
                if_req = 1'b0;
                break;
            end
        end
        chk("both_dm_cycle", cyc_dm, 5);
        chk("both_if_cycle", cyc_if, 11);
        chk("both_stall", {31'h0, stall_ok}, 32'h1);
        chk("both_dm_rdata", dm_rdata, 32'h11223344);
        chk("both_if_rdata", if_rdata, 32'h24050010);
        @(negedge clk);

        // Misaligned word store at 0x102.
        dm_start(1'b1, 2'b10, 1'b0, 9'h102, 32'hCAFEF00D);
        we_seen = 1'b0;
        cyc     = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_we) we_seen = 1'b1;
            if (dm_done) begin
                cyc = k + 1;
                break;
            end
        end
        chk("mis_cycle", cyc, 1);
        chk("mis_err", {31'h0, dm_err}, 32'h1);
        chk("mis_rdata", dm_rdata, 32'h0);
        chk("mis_no_we", {31'h0, we_seen}, 32'h0);
        dm_req = 1'b0;
        @(negedge clk);
        chk("mis_err_clear", {31'h0, dm_err}, 32'h0);
        chk("mis_mem", {24'h0, mem[9'h102]}, 32'h5A);

        // Reserved size is an error even when aligned.
        dm_start(1'b0, 2'b11, 1'b0, 9'h000, 32'h0);
        wait_dm(0, cyc);
        chk("rsvd_cycle", cyc, 1);
        chk("rsvd_err", {31'h0, dm_err}, 32'h1);
        dm_req = 1'b0;
        @(negedge clk);

        // Reset asserted during beat 2 of a word store.
        dm_start(1'b1, 2'b10, 1'b0, 9'h080, 32'hA1B2C3D4);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_pre_addr", {23'h0, mem_addr}, 32'h082);
        reset = 1'b1;
        #1;
        chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
        chk("abort_mem_addr", {23'h0, mem_addr}, 32'h0);
        chk("abort_dm_done", {31'h0, dm_done}, 32'h0);
        chk("abort_rdata", {if_rdata | dm_rdata}, 32'h0);
        dm_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc_dm = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (dm_done) cyc_dm = 1;
        end
        chk("abort_no_done", cyc_dm, 0);
        chk("abort_mem", {mem[9'h080], mem[9'h081], mem[9'h082], mem[9'h083]}, 32'hA1B20304);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
